// File: rtl/irq_request_reg.sv
// Interrupt request register: synchronises N raw request lines and latches them in edge or level mode.
// Acknowledges clear the named channel, and edge requests lost while the channel is still pending are flagged.
module irq_request_reg #(
  parameter int N_IR        = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (N_IR > 1) ? $clog2(N_IR) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N_IR-1:0] ir_in_i,
  input  logic [N_IR-1:0] ltim_i,
  input  logic [N_IR-1:0] imr_i,
  input  logic            ack_valid_i,
  input  logic [ID_W-1:0] ack_id_i,
  input  logic            init_i,
  input  logic            ovr_clr_i,
  output logic [N_IR-1:0] irr_o,
  output logic [N_IR-1:0] irr_masked_o,
  output logic            int_req_o,
  output logic [N_IR-1:0] overrun_o
);

  logic [SYNC_STAGES-1:0][N_IR-1:0] sync_q;
  logic [N_IR-1:0] s_prev_q, s_prev_d;
  logic [N_IR-1:0] irr_q, irr_d;
  logic [N_IR-1:0] overrun_q, overrun_d;
  logic [N_IR-1:0] sync_s, rise_s, hit_s;

  // Synchroniser chain; INIT deliberately leaves it untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ir_in_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise_s = sync_s & ~s_prev_q;

  // Acknowledge decode; out-of-range IDs match no channel.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < N_IR; i++) begin
      hit_s[i] = ack_valid_i && (ack_id_i == ID_W'(i));
    end
  end

  // Next-state for IRR, OVERRUN and the edge-detect history.
  always_comb begin
    s_prev_d  = sync_s;
    irr_d     = irr_q;
    overrun_d = overrun_q;
    if (init_i) begin
      irr_d     = '0;
      overrun_d = '0;
    end else begin
      for (int i = 0; i < N_IR; i++) begin
        if (ltim_i[i]) begin
          irr_d[i] = sync_s[i] & ~hit_s[i];
        end else if (rise_s[i]) begin
          // A fresh edge beats a same-cycle acknowledge.
          irr_d[i] = 1'b1;
        end else if (hit_s[i]) begin
          irr_d[i] = 1'b0;
        end else begin
          irr_d[i] = irr_q[i];
        end
      end
      if (ovr_clr_i) begin
        overrun_d = '0;
      end else begin
        overrun_d = overrun_q | (~ltim_i & rise_s & irr_q & ~hit_s);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_prev_q  <= '0;
      irr_q     <= '0;
      overrun_q <= '0;
    end else begin
      s_prev_q  <= s_prev_d;
      irr_q     <= irr_d;
      overrun_q <= overrun_d;
    end
  end

  assign irr_o        = irr_q;
  assign overrun_o    = overrun_q;
  assign irr_masked_o = irr_q & ~imr_i;
  assign int_req_o    = |irr_masked_o;

endmodule

// File: tb/tb_irq_request_reg.sv
// Directed self-checking bench for irq_request_reg (N_IR=8, SYNC_STAGES=2).
module tb_irq_request_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir_in, ltim, imr;
  logic       ack_valid;
  logic [2:0] ack_id;
  logic       init, ovr_clr;
  logic [7:0] irr, irr_masked, overrun;
  logic       int_req;

  int tests = 0;
  int fails = 0;

  irq_request_reg #(.N_IR(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ir_in_i(ir_in), .ltim_i(ltim), .imr_i(imr),
    .ack_valid_i(ack_valid), .ack_id_i(ack_id), .init_i(init), .ovr_clr_i(ovr_clr),
    .irr_o(irr), .irr_masked_o(irr_masked), .int_req_o(int_req), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack(input logic [2:0] id);
    ack_valid = 1'b1;
    ack_id    = id;
    tick(1);
    ack_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ir_in = 8'hFF; ltim = 8'h00; imr = 8'h00;
    ack_valid = 1'b0; ack_id = 3'd0; init = 1'b0; ovr_clr = 1'b0;
    #1;
    tests++; if (irr !== 8'h00 || int_req !== 1'b0) begin fails++; $display("FAIL reset_async irr=%h int_req=%b exp 00/0", irr, int_req); end
    tick(3);
    tests++; if (irr !== 8'h00 || overrun !== 8'h00 || int_req !== 1'b0) begin fails++; $display("FAIL reset_held irr=%h ovr=%h int_req=%b exp 00/00/0", irr, overrun, int_req); end
    rst_n = 1'b1;
    tick(2);
    tests++; if (irr !== 8'h00) begin fails++; $display("FAIL reset_latency_early irr=%h exp 00", irr); end
    tick(1);
    tests++; if (irr !== 8'hFF || int_req !== 1'b1) begin fails++; $display("FAIL reset_release_rise irr=%h int_req=%b exp FF/1", irr, int_req); end
    ir_in = 8'h00;
    tick(3);
    init = 1'b1; tick(1); init = 1'b0;
    tests++; if (irr !== 8'h00 || overrun !== 8'h00) begin fails++; $display("FAIL reset_init_clear irr=%h ovr=%h exp 00/00", irr, overrun); end
  endtask

  task automatic test_edge_ack;
    ir_in = 8'h08;
    tick(2);
    ir_in = 8'h00;
    tick(1);
    tests++; if (irr !== 8'h08 || int_req !== 1'b1) begin fails++; $display("FAIL edge_latch irr=%h int_req=%b exp 08/1", irr, int_req); end
    tick(2);
    tests++; if (irr !== 8'h08) begin fails++; $display("FAIL edge_hold irr=%h exp 08", irr); end
    ack(3'd3);
    tests++; if (irr !== 8'h00) begin fails++; $display("FAIL edge_ack irr=%h exp 00", irr); end
    tick(3);
    tests++; if (irr !== 8'h00 || int_req !== 1'b0) begin fails++; $display("FAIL edge_no_relatch irr=%h int_req=%b exp 00/0", irr, int_req); end
  endtask

  task automatic test_level;
    ltim = 8'h20; ir_in = 8'h20;
    tick(3);
    tests++; if (irr !== 8'h20) begin fails++; $display("FAIL level_set irr=%h exp 20", irr); end
    ir_in = 8'h00;
    tick(2);
    tests++; if (irr !== 8'h20) begin fails++; $display("FAIL level_drop_early irr=%h exp 20", irr); end
    tick(1);
    tests++; if (irr !== 8'h00) begin fails++; $display("FAIL level_drop irr=%h exp 00", irr); end
    ir_in = 8'h20;
    tick(3);
    ack(3'd5);
    tests++; if (irr !== 8'h00) begin fails++; $display("FAIL level_ack_clear irr=%h exp 00", irr); end
    tick(1);
    tests++; if (irr !== 8'h20) begin fails++; $display("FAIL level_reassert irr=%h exp 20", irr); end
    ir_in = 8'h00;
    tick(3);
    ltim = 8'h00;
  endtask

  task automatic test_overrun;
    ir_in = 8'h04; tick(2); ir_in = 8'h00; tick(3);
    tests++; if (irr !== 8'h04 || overrun !== 8'h00) begin fails++; $display("FAIL ovr_pending irr=%h ovr=%h exp 04/00", irr, overrun); end
    ir_in = 8'h04;
    tick(3);
    tests++; if (irr !== 8'h04 || overrun !== 8'h04) begin fails++; $display("FAIL ovr_set irr=%h ovr=%h exp 04/04", irr, overrun); end
    ir_in = 8'h00;
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    tests++; if (irr !== 8'h04 || overrun !== 8'h00) begin fails++; $display("FAIL ovr_clr irr=%h ovr=%h exp 04/00", irr, overrun); end
    tick(3);
    ir_in = 8'h04;
    tick(2);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    tests++; if (overrun !== 8'h00) begin fails++; $display("FAIL ovr_clr_wins ovr=%h exp 00", overrun); end
    ir_in = 8'h00; tick(3);
    ir_in = 8'h04; tick(3);
    tests++; if (overrun !== 8'h04) begin fails++; $display("FAIL ovr_next_rise ovr=%h exp 04", overrun); end
    ir_in = 8'h00; tick(3);
    ack(3'd2);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    tests++; if (irr !== 8'h00 || overrun !== 8'h00) begin fails++; $display("FAIL ovr_cleanup irr=%h ovr=%h exp 00/00", irr, overrun); end
  endtask

  task automatic test_mask_simul;
    imr = 8'h01; ir_in = 8'h01;
    tick(3);
    tests++; if (irr !== 8'h01 || irr_masked !== 8'h00 || int_req !== 1'b0) begin fails++; $display("FAIL mask_gate irr=%h msk=%h int_req=%b exp 01/00/0", irr, irr_masked, int_req); end
    imr = 8'h00; #1;
    tests++; if (irr_masked !== 8'h01 || int_req !== 1'b1) begin fails++; $display("FAIL mask_release msk=%h int_req=%b exp 01/1", irr_masked, int_req); end
    ir_in = 8'h00; tick(3); ack(3'd0);
    ir_in = 8'h02; tick(2); ir_in = 8'h00; tick(3);
    ir_in = 8'h02; tick(2);
    ack(3'd1);
    tests++; if (irr !== 8'h02 || overrun !== 8'h00) begin fails++; $display("FAIL ack_vs_rise irr=%h ovr=%h exp 02/00", irr, overrun); end
    ir_in = 8'h00; tick(3); ack(3'd1);
  endtask

  task automatic test_mode_change;
    ltim = 8'h10; ir_in = 8'h10;
    tick(3);
    ltim = 8'h00;
    tick(1);
    tests++; if (irr !== 8'h10) begin fails++; $display("FAIL mode_to_edge irr=%h exp 10", irr); end
    ack(3'd4);
    tick(2);
    tests++; if (irr !== 8'h00) begin fails++; $display("FAIL mode_no_toggle_rise irr=%h exp 00", irr); end
    ltim = 8'h10;
    tick(1);
    tests++; if (irr !== 8'h10) begin fails++; $display("FAIL mode_to_level irr=%h exp 10", irr); end
    ir_in = 8'h00; tick(3); ltim = 8'h00;
  endtask

  task automatic test_init;
    ir_in = 8'h80;
    tick(2);
    init = 1'b1; tick(1); init = 1'b0;
    tests++; if (irr !== 8'h00 || overrun !== 8'h00) begin fails++; $display("FAIL init_clear irr=%h ovr=%h exp 00/00", irr, overrun); end
    tick(4);
    tests++; if (irr !== 8'h00) begin fails++; $display("FAIL init_no_edge irr=%h exp 00", irr); end
    ir_in = 8'h00; tick(3);
    ir_in = 8'h80; tick(3);
    tests++; if (irr !== 8'h80) begin fails++; $display("FAIL init_new_edge irr=%h exp 80", irr); end
  endtask

  initial begin
    test_reset();
    test_edge_ack();
    test_level();
    test_overrun();
    test_mask_simul();
    test_mode_change();
    test_init();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
